// File: rtl/ula_seq_pkg.sv
// Shared definitions for the ula sequencer: command codes, FSM states and
// the sign-magnitude widths used between the key decoder and the ula.
package ula_seq_pkg;

    localparam int SM_W    = 8;    // sign-magnitude operand width
    localparam int RES_W   = 9;    // ula result width (sign + 8-bit magnitude)
    localparam int MAG_MAX = 127;  // largest magnitude an operand can hold

    // Command codes from the key decoder; 5..7 are accepted and ignored.
    localparam logic [2:0] CMD_LOAD_A = 3'd0;
    localparam logic [2:0] CMD_LOAD_B = 3'd1;
    localparam logic [2:0] CMD_ADD    = 3'd2;
    localparam logic [2:0] CMD_SUB    = 3'd3;
    localparam logic [2:0] CMD_CLEAR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Lift an 8-bit operand into result format so one normaliser serves both paths.
    function automatic logic [RES_W-1:0] widen_operand(input logic [SM_W-1:0] op);
        return {op[SM_W-1], 1'b0, op[SM_W-2:0]};
    endfunction

endpackage

// File: rtl/ula_seq_norm.sv
// Combinational result normaliser: folds -0 to +0, flags magnitudes above
// 127 and, when ULA_SEQ_SAT_EN is defined, clamps them to 127 keeping the sign.
// fits tells the caller whether res can be written back into an 8-bit operand.
module ula_seq_norm
    import ula_seq_pkg::*;
(
    input  logic [RES_W-1:0] raw,
    output logic [RES_W-1:0] res,
    output logic             ovf,
    output logic             fits
);

    // Overflow detect, optional saturation, then -0 fold
    always_comb begin
        ovf  = raw[SM_W-1:0] > 8'(MAG_MAX);
        res  = raw;
        fits = ~ovf;
`ifdef ULA_SEQ_SAT_EN
        if (ovf) begin
            res  = {raw[RES_W-1], 8'(MAG_MAX)};
            fits = 1'b1;
        end
`else
        // Raw result passes through; an overflowed value cannot be reloaded.
`endif
        if (raw[SM_W-1:0] == 8'h00) begin
            res = '0;
        end
    end

endmodule

// File: rtl/ula_seq_ctrl.sv
// Sequencer between the remote-control key decoder and the ula add/sub ALU.
// Loads operands, launches ADD/SUB, waits ALU_LAT+1 cycles, captures and
// normalises the result, and writes it back to alu_a for chained operations.
// Build option: ULA_SEQ_SAT_EN saturates overflowed results to magnitude 127.
module ula_seq_ctrl
    import ula_seq_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_code,
    input  logic [SM_W-1:0]   cmd_data,
    output logic [SM_W-1:0]   alu_a,
    output logic [SM_W-1:0]   alu_b,
    output logic              alu_op,
    input  logic [RES_W-1:0]  alu_r,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    output logic              ovf,
    output logic              err,
    output logic              busy
);

    localparam int              CNT_W    = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             is_alu_cmd;
    logic [RES_W-1:0] norm_in, norm_res;
    logic             norm_ovf, norm_fits;
    logic [SM_W-1:0]  norm_operand;

    assign busy       = ~cmd_ready;
    assign accept     = cmd_valid && cmd_ready;
    assign is_alu_cmd = (cmd_code == CMD_ADD) || (cmd_code == CMD_SUB);

    // The normaliser sees the ula result while capturing, the incoming operand otherwise.
    assign norm_in      = (state == ST_CAPTURE) ? alu_r : widen_operand(cmd_data);
    assign norm_operand = {norm_res[RES_W-1], norm_res[SM_W-2:0]};

    ula_seq_norm u_norm (
        .raw  (norm_in),
        .res  (norm_res),
        .ovf  (norm_ovf),
        .fits (norm_fits)
    );

    // FSM state and latency counter registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: only ADD/SUB leave IDLE; EXEC waits out the ula latency
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                cnt_next  = '0;
                if (cmd_valid && is_alu_cmd) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_CAPTURE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand, result and flag registers; operands stay frozen outside IDLE/CAPTURE
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_code)
                            CMD_LOAD_A: alu_a <= norm_operand;
                            CMD_LOAD_B: alu_b <= norm_operand;
                            CMD_ADD,
                            CMD_SUB:    alu_op <= cmd_code[0];
                            CMD_CLEAR: begin
                                alu_a    <= '0;
                                alu_b    <= '0;
                                res_data <= '0;
                                ovf      <= 1'b0;
                                err      <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CAPTURE: begin
                    res_valid <= 1'b1;
                    res_data  <= norm_res;
                    ovf       <= norm_ovf;
                    if (norm_ovf) begin
                        err <= 1'b1;
                    end
                    // Accumulate only when the result fits an operand (in range or saturated).
                    if (norm_fits) begin
                        alu_a <= norm_operand;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
